spi_mem_ctrl: RTL

Command sequencer between the SPI byte deserializer/serializer and the 8-bit simple dual-port, negedge-clocked frame RAM. Decodes SPI-memory style commands from the received byte stream, drives RAM port A for writes and port B for reads with auto-incrementing, wrapping addresses, and presents read bytes to the serializer. All logic runs on the rising edge; the RAM samples on the intervening falling edge.

---
 rtl/spi_mem_pkg.sv | 24 ++
 rtl/spi_mem_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/spi_mem_pkg.sv
// Shared opcodes, sequencer states and status-byte layout for the SPI memory
// command sequencer.
package spi_mem_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRDI  = 8'h04;

  // Status byte: bit 1 reflects the write-enable latch, all other bits read 0.
  localparam int STS_WEL = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_READ,
    ST_WRITE,
    ST_STATUS,
    ST_IGNORE
  } state_e;

endpackage

// File: rtl/spi_mem_ctrl.sv
// Command sequencer between the SPI byte shifter and a negedge-clocked dual-port
// frame RAM: decodes opcodes, streams reads/writes with a wrapping address.
module spi_mem_ctrl
  import spi_mem_pkg::*;
#(
  parameter int ADDRL = 14
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             frame_active_i,
  input  logic             rx_valid_i,
  input  logic [7:0]       rx_data_i,
  input  logic             tx_req_i,
  output logic [7:0]       tx_data_o,
  output logic             tx_valid_o,
  output logic             ram_ena_o,
  output logic             ram_wea_o,
  output logic [ADDRL-1:0] ram_addra_o,
  output logic [7:0]       ram_dia_o,
  output logic             ram_enb_o,
  output logic [ADDRL-1:0] ram_addrb_o,
  input  logic [7:0]       ram_dob_i,
  output logic             wel_o
);

  state_e           state_q, state_d;
  logic [ADDRL-1:0] addr_q, addr_d;
  logic             wel_q, wel_d;
  logic             cmd_wr_q, cmd_wr_d;   // frame carries an accepted WRITE
  logic             rd_pend_q, rd_pend_d; // RAM read issued, capture this cycle
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             ena_q, ena_d, wea_q, wea_d, enb_q, enb_d;
  logic [ADDRL-1:0] addra_q, addra_d, addrb_q, addrb_d;
  logic [7:0]       dia_q, dia_d;

  logic [15:0]      addr16;
  logic [ADDRL-1:0] addr_lo_w, addr_inc;

  // Address arrives as 16 wire bits; bits above ADDRL fall away on truncation.
  assign addr16    = 16'(addr_q);
  assign addr_lo_w = ADDRL'({addr16[15:8], rx_data_i});
  assign addr_inc  = addr_q + ADDRL'(1);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wel_d      = wel_q;
    cmd_wr_d   = cmd_wr_q;
    rd_pend_d  = 1'b0;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    ena_d      = 1'b0;
    wea_d      = 1'b0;
    enb_d      = 1'b0;
    addra_d    = addra_q;
    addrb_d    = addrb_q;
    dia_d      = dia_q;
    if (!frame_active_i) begin
      state_d    = ST_IDLE;
      tx_valid_d = 1'b0;
      tx_data_d  = 8'h00;
      cmd_wr_d   = 1'b0;
      if (cmd_wr_q) wel_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (rx_valid_i) begin
          cmd_wr_d = 1'b0;
          case (rx_data_i)
            OP_READ:  state_d = ST_ADDR_HI;
            OP_WRITE: begin
              state_d  = wel_q ? ST_ADDR_HI : ST_IGNORE;
              cmd_wr_d = wel_q;
            end
            OP_RDSR:  state_d = ST_STATUS;
            OP_WREN:  begin wel_d = 1'b1; state_d = ST_IGNORE; end
            OP_WRDI:  begin wel_d = 1'b0; state_d = ST_IGNORE; end
            default:  state_d = ST_IGNORE;
          endcase
        end
        ST_ADDR_HI: if (rx_valid_i) begin
          addr_d  = ADDRL'({rx_data_i, 8'h00});
          state_d = ST_ADDR_LO;
        end
        ST_ADDR_LO: if (rx_valid_i) begin
          addr_d = addr_lo_w;
          if (cmd_wr_q) begin
            state_d = ST_WRITE;
          end else begin
            state_d   = ST_READ;
            enb_d     = 1'b1;
            addrb_d   = addr_lo_w;
            rd_pend_d = 1'b1;
          end
        end
        ST_READ: begin
          // Requests are only honoured once the previous byte has landed.
          if (rd_pend_q) begin
            tx_data_d  = ram_dob_i;
            tx_valid_d = 1'b1;
            addr_d     = addr_inc;
          end else if (tx_req_i && tx_valid_q) begin
            enb_d     = 1'b1;
            addrb_d   = addr_q;
            rd_pend_d = 1'b1;
          end
        end
        ST_WRITE: if (rx_valid_i) begin
          ena_d   = 1'b1;
          wea_d   = 1'b1;
          addra_d = addr_q;
          dia_d   = rx_data_i;
          addr_d  = addr_inc;
        end
        ST_STATUS: begin
          tx_data_d          = 8'h00;
          tx_data_d[STS_WEL] = wel_q;
          tx_valid_d         = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wel_q      <= 1'b0;
      cmd_wr_q   <= 1'b0;
      rd_pend_q  <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      ena_q      <= 1'b0;
      wea_q      <= 1'b0;
      enb_q      <= 1'b0;
      addra_q    <= '0;
      addrb_q    <= '0;
      dia_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wel_q      <= wel_d;
      cmd_wr_q   <= cmd_wr_d;
      rd_pend_q  <= rd_pend_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      ena_q      <= ena_d;
      wea_q      <= wea_d;
      enb_q      <= enb_d;
      addra_q    <= addra_d;
      addrb_q    <= addrb_d;
      dia_q      <= dia_d;
    end
  end

  assign tx_data_o   = tx_data_q;
  assign tx_valid_o  = tx_valid_q;
  assign ram_ena_o   = ena_q;
  assign ram_wea_o   = wea_q;
  assign ram_addra_o = addra_q;
  assign ram_dia_o   = dia_q;
  assign ram_enb_o   = enb_q;
  assign ram_addrb_o = addrb_q;
  assign wel_o       = wel_q;

endmodule
